icache_sa: RTL and testbench
============================

// Module: icache_sa
// PURPOSE
//  Parametrised set-associative instruction cache for the fetch stage, between PC and memory.
//  Generalises the direct-mapped iCache with N-way sets and round-robin replacement.
//  Adds a valid/ready fetch handshake, a line-fill FSM, flush support and hit/miss counters.
//  Hits return one word per cycle. Misses fetch a whole line from memory and then return the word.
// PARAMETERS
//  ADDR_WIDTH   32  fetch address width; TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W
//  LINE_BYTES   16  bytes per line (power of 2, >=4); OFFSET_W = log2(LINE_BYTES)
//  NSETS         4  number of sets (power of 2); INDEX_W = log2(NSETS)
//  NWAYS         2  ways per set (>=1); NWAYS=1 degenerates to direct-mapped
//  CNT_WIDTH    32  width of the hit/miss counters
// PORTS
//  clk             in   1               single clock, all state updates on posedge
//  reset           in   1               synchronous, active-high
//  req_valid       in   1               fetch request valid
//  req_addr        in   ADDR_WIDTH      fetch byte address; bits [1:0] ignored
//  req_ready       out  1               cache accepts a request this cycle
//  flush           in   1               invalidate all lines (level, sampled on posedge)
//  resp_valid      out  1               resp_instr valid (one-cycle pulse per request)
//  resp_instr      out  32              fetched instruction word
//  resp_hit        out  1               qualifies resp_valid: 1=hit, 0=served by fill
//  mem_req         out  1               line-fill request to memory
//  mem_req_addr    out  ADDR_WIDTH      line-aligned fill address (offset bits zero)
//  mem_resp_valid  in   1               fill data valid
//  mem_resp_data   in   LINE_BYTES*8    fill line; word k at bits [32k+31:32k]
//  hit_count       out  CNT_WIDTH       saturating count of hit responses
//  miss_count      out  CNT_WIDTH       saturating count of miss responses
// BEHAVIOUR
//  Address split: tag=[ADDR_WIDTH-1:INDEX_W+OFFSET_W], index=[INDEX_W+OFFSET_W-1:OFFSET_W],
//   word=[OFFSET_W-1:2].
//  Reset: FSM=IDLE; all valid bits and rr_ptr cleared to 0; counters cleared to 0.
//   resp_valid, resp_hit, mem_req, mem_req_addr and resp_instr reset to 0.
//   Tag and data arrays are not reset.
//  Reset mid-miss abandons the fill. mem_req is 0 after that edge, and a late mem_resp_valid is ignored.
//  FSM states: IDLE, FILL_WAIT, FLUSH.
//   IDLE: req_ready=1 unless flush=1.
//    flush=1 -> FLUSH; it has priority over req_valid, and no request is accepted that cycle.
//    req_valid&hit -> next cycle resp_valid=1, resp_hit=1, word from the hit way; stay IDLE.
//     Back-to-back hits sustain 1 response per cycle.
//    req_valid&miss -> FILL_WAIT. Next cycle mem_req=1, mem_req_addr=line address; request addr latched.
//   FILL_WAIT: req_ready=0. mem_req stays high until the edge where mem_resp_valid=1.
//    On that edge: write data and tag, set valid in the victim way, then go to IDLE.
//    Next cycle: mem_req=0, resp_valid=1, resp_hit=0, resp_instr=selected word of mem_resp_data.
//   FLUSH: clear all valid bits and rr_ptr in one cycle, req_ready=0, then go to IDLE.
//   flush asserted during FILL_WAIT sets flush_pend. The fill completes and responds, then FLUSH runs.
//  Victim selection: lowest-numbered invalid way in the set.
//   If no way is invalid: way rr_ptr[set], then rr_ptr[set] <= (rr_ptr[set]+1) mod NWAYS.
//  A hit never changes rr_ptr. At most one way may match a tag (guaranteed by fill).
//  mem_resp_valid outside FILL_WAIT is ignored.
//  resp_valid is high for exactly one cycle per accepted request. resp_instr holds until the next response.
//  Counters increment on each resp_valid (hit or miss) and saturate at all-ones.
// TESTING (defaults: 4 sets, 2 ways, 16B lines; set0 addrs 0x00/0x40/0x80)
//  Cold miss: req 0x40 -> next cycle mem_req=1, mem_req_addr=0x40.
//   Give mem_resp_data=128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> resp_instr=0xDDDDDDDD, resp_hit=0.
//  Hit streaming: reqs 0x4C,0x48,0x44 on 3 consecutive cycles -> 3 consecutive responses.
//   Expected: 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, all resp_hit=1; hit_count=3.
//  Replacement: fill 0x00 (way0), 0x40 (way1), then 0x80 evicts way0.
//   Then req 0x40 -> hit; req 0x00 -> miss.
//  Flush: after filling 0x40, pulse flush for 1 cycle -> req_ready=0 for 1 cycle.
//   Then req 0x40 -> miss and mem_req; miss_count increments.
//  Flush during fill: assert flush in FILL_WAIT -> fill response still returned, then FLUSH.
//   Then req 0x40 -> miss.
//  Reset mid-miss: reset while mem_req=1 -> next cycle mem_req=0, resp_valid=0.
//   A later mem_resp_valid produces no response; req 0x40 then misses.

Source files
------------

// File: rtl/icache_if.sv
// Fetch/fill bus of the set-associative instruction cache.
// slave  = cache side (accepts fetches, issues line fills).
// master = fetch stage plus memory side (drives requests and fill data).
interface icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int CNT_WIDTH  = 32
);
    logic                    req_valid;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_ready;
    logic                    flush;
    logic                    resp_valid;
    logic [31:0]             resp_instr;
    logic                    resp_hit;
    logic                    mem_req;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic                    mem_resp_valid;
    logic [LINE_BYTES*8-1:0] mem_resp_data;
    logic [CNT_WIDTH-1:0]    hit_count;
    logic [CNT_WIDTH-1:0]    miss_count;

    modport slave (
        input  req_valid, req_addr, flush, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_instr, resp_hit,
               mem_req, mem_req_addr, hit_count, miss_count
    );

    modport master (
        output req_valid, req_addr, flush, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_instr, resp_hit,
               mem_req, mem_req_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_sa.sv
// N-way set-associative instruction cache with round-robin replacement,
// valid/ready fetch handshake, whole-line fill FSM, flush and hit/miss counters.
module icache_sa #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int NSETS      = 4,
    parameter int NWAYS      = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic     clk,
    input  logic     reset,
    icache_if.slave  bus
);
    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int INDEX_W  = $clog2(NSETS);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int LINE_W   = LINE_BYTES * 8;
    localparam int SET_W    = (INDEX_W > 0) ? INDEX_W : 1;
    localparam int WAY_W    = (NWAYS > 1) ? $clog2(NWAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL_WAIT, FLUSH} state_t;

    function automatic logic [SET_W-1:0] set_of(input logic [ADDR_WIDTH-1:0] a);
        return SET_W'((a >> OFFSET_W) & ADDR_WIDTH'(NSETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
        return TAG_W'(a >> (OFFSET_W + INDEX_W));
    endfunction

    // Word select inside a line; byte bits [1:0] only drop out of the divide.
    function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line,
                                            input logic [ADDR_WIDTH-1:0] a);
        int idx;
        idx = int'(a[OFFSET_W-1:0]) / 4;
        return line[32*idx +: 32];
    endfunction

    state_t                  state_q, state_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [NWAYS-1:0]        valid_q [NSETS];
    logic [WAY_W-1:0]        rr_q    [NSETS];
    logic [TAG_W-1:0]        tag_q   [NSETS][NWAYS];
    logic [LINE_W-1:0]       data_q  [NSETS][NWAYS];
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    resp_valid_q, resp_hit_q, mem_req_q;
    logic [31:0]             resp_instr_q;
    logic [ADDR_WIDTH-1:0]   mem_req_addr_q;
    logic [CNT_WIDTH-1:0]    hit_cnt_q, miss_cnt_q;

    logic                    ready, accept_hit, accept_miss, fill_done, flush_now;
    logic                    hit;
    logic [WAY_W-1:0]        hit_way, victim, rr_next;
    logic                    any_invalid;
    logic [SET_W-1:0]        req_set, fill_set;
    logic [TAG_W-1:0]        req_tag;

    assign req_set  = set_of(bus.req_addr);
    assign req_tag  = tag_of(bus.req_addr);
    assign fill_set = set_of(addr_q);

    // Tag lookup of the incoming fetch address across all ways of its set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim for the pending fill: lowest invalid way, else the round-robin way.
    always_comb begin
        victim      = rr_q[fill_set];
        any_invalid = 1'b0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!valid_q[fill_set][w]) begin
                victim      = WAY_W'(w);
                any_invalid = 1'b1;
            end
        end
        rr_next = (rr_q[fill_set] == WAY_W'(NWAYS - 1)) ? '0 : rr_q[fill_set] + WAY_W'(1);
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        ready        = 1'b0;
        accept_hit   = 1'b0;
        accept_miss  = 1'b0;
        fill_done    = 1'b0;
        flush_now    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                end else begin
                    ready = 1'b1;
                    if (bus.req_valid) begin
                        if (hit) begin
                            accept_hit = 1'b1;
                        end else begin
                            accept_miss = 1'b1;
                            state_d     = FILL_WAIT;
                        end
                    end
                end
            end
            FILL_WAIT: begin
                if (bus.flush) flush_pend_d = 1'b1;
                if (bus.mem_resp_valid) begin
                    fill_done    = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = (flush_pend_q || bus.flush) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                flush_now = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any fill in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Response, fill request and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_instr_q   <= '0;
            mem_req_q      <= 1'b0;
            mem_req_addr_q <= '0;
            addr_q         <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
        end else begin
            resp_valid_q <= accept_hit | fill_done;
            if (accept_hit) begin
                resp_hit_q   <= 1'b1;
                resp_instr_q <= word_of(data_q[req_set][hit_way], bus.req_addr);
                if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end
            if (accept_miss) begin
                mem_req_q      <= 1'b1;
                mem_req_addr_q <= {bus.req_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                addr_q         <= bus.req_addr;
            end
            if (fill_done) begin
                mem_req_q    <= 1'b0;
                resp_hit_q   <= 1'b0;
                resp_instr_q <= word_of(bus.mem_resp_data, addr_q);
                if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Valid bits and round-robin pointers: cleared by reset/flush, updated on fill.
    always_ff @(posedge clk) begin
        if (reset || flush_now) begin
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (fill_done) begin
            valid_q[fill_set][victim] <= 1'b1;
            if (!any_invalid) rr_q[fill_set] <= rr_next;
        end
    end

    // Tag and data storage written on fill.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays carry no reset; a cleared valid bit makes their contents irrelevant.
        if (fill_done) begin
            tag_q[fill_set][victim]  <= tag_of(addr_q);
            data_q[fill_set][victim] <= bus.mem_resp_data;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_instr   = resp_instr_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_req_addr = mem_req_addr_q;
    assign bus.hit_count    = hit_cnt_q;
    assign bus.miss_count   = miss_cnt_q;
endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: directed scenarios plus randomized fetch/flush
// traffic checked against a line-level reference model of the cache.
module tb_icache_sa;
    localparam int AW = 32, LB = 16, NS = 4, NW = 2, CW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .CNT_WIDTH(CW)) bus ();

    icache_sa #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .NSETS(NS), .NWAYS(NW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        bit          hit;
    } resp_t;

    int errors = 0;
    int checks = 0;

    resp_t          exp_q[$];
    logic [AW-1:0]  exp_fill_q[$];

    // Reference model: per set, NW slots each holding a line address and its data.
    bit             m_valid [NS][NW];
    logic [AW-1:0]  m_line  [NS][NW];
    logic [127:0]   m_data  [NS][NW];
    int             m_rr    [NS];
    int             exp_hits, exp_misses;

    bit             force_en;
    logic [127:0]   force_line;
    logic [31:0]    salt;
    bit             resp_block;
    int             fixed_delay;
    int             late_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing memory content of a line.
    function automatic logic [127:0] line_data(input logic [AW-1:0] line);
        logic [127:0] d;
        if (force_en) return force_line;
        for (int k = 0; k < 4; k++)
            d[32*k +: 32] = (line * 32'h9E3779B1) ^ salt ^ (32'(k) * 32'h01010101);
        return d;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        model_flush();
        exp_hits   = 0;
        exp_misses = 0;
        exp_q.delete();
        exp_fill_q.delete();
    endfunction

    // Predict the response to a fetch and update the model.
    function automatic void predict(input logic [AW-1:0] addr);
        int s, w, way;
        logic [AW-1:0] line;
        s    = int'((addr / LB) % NS);
        w    = int'((addr % LB) / 4);
        line = addr - (addr % LB);
        way  = -1;
        for (int i = 0; i < NW; i++)
            if (m_valid[s][i] && m_line[s][i] == line) way = i;
        if (way >= 0) begin
            exp_q.push_back('{instr: m_data[s][way][32*w +: 32], hit: 1'b1});
            exp_hits++;
        end else begin
            for (int i = 0; i < NW; i++)
                if (!m_valid[s][i] && way < 0) way = i;
            if (way < 0) begin
                way     = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % NW;
            end
            m_valid[s][way] = 1'b1;
            m_line[s][way]  = line;
            m_data[s][way]  = line_data(line);
            exp_q.push_back('{instr: m_data[s][way][32*w +: 32], hit: 1'b0});
            exp_misses++;
            exp_fill_q.push_back(line);
        end
    endfunction

    // Response monitor.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_instr", 64'(bus.resp_instr), 64'(e.instr));
                    check("resp_hit", 64'(bus.resp_hit), 64'(e.hit));
                end
            end
        end
    end

    // Memory model: answers each fill after a short delay; sole driver of mem_resp_*.
    initial begin : mem_model
        int delay, late_done;
        bit busy;
        logic [AW-1:0] a;
        delay = 0; busy = 1'b0; late_done = 0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (late_cnt != late_done) begin
                late_done++;
                bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
                bus.mem_resp_valid = 1'b1;
            end else if (!resp_block && bus.mem_req === 1'b1) begin
                if (!busy) begin
                    busy  = 1'b1;
                    delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (delay == 0) begin
                    busy = 1'b0;
                    if (exp_fill_q.size() == 0) begin
                        check("fill_unexpected", 64'(bus.mem_req), 64'd0);
                    end else begin
                        a = exp_fill_q.pop_front();
                        check("mem_req_addr", 64'(bus.mem_req_addr), 64'(a));
                    end
                    bus.mem_resp_data  = line_data(bus.mem_req_addr);
                    bus.mem_resp_valid = 1'b1;
                end else begin
                    delay--;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic issue(input logic [AW-1:0] addr);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        predict(addr);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_flush();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit_count"}, 64'(bus.hit_count), 64'(exp_hits));
        check({tag, "_miss_count"}, 64'(bus.miss_count), 64'(exp_misses));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int r;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        force_en      = 1'b0;
        force_line    = '0;
        salt          = 32'h1234_5678;
        resp_block    = 1'b0;
        fixed_delay   = -1;
        late_cnt      = 0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        check("rst_resp_instr", 64'(bus.resp_instr), 64'd0);
        check("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_counts("rst");

        // Cold miss then hit streaming from the same line
        force_en   = 1'b1;
        force_line = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        issue(32'h40);
        check("cold_mem_req", 64'(bus.mem_req), 64'd1);
        check("cold_mem_addr", 64'(bus.mem_req_addr), 64'h40);
        check("cold_ready_low", 64'(bus.req_ready), 64'd0);
        drain();
        issue(32'h4C);
        issue(32'h48);
        issue(32'h44);
        drain();
        check_counts("stream");
        force_en = 1'b0;

        // Flush after a fill: one FLUSH cycle, then the line misses again
        flush_pulse();
        check("flush_ready_low", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("flush_ready_back", 64'(bus.req_ready), 64'd1);
        issue(32'h40);
        drain();
        check_counts("flush");

        // Replacement in set 0
        flush_pulse();
        issue(32'h00);
        issue(32'h40);
        issue(32'h80);
        issue(32'h40);
        issue(32'h00);
        drain();
        check_counts("repl");

        // Flush raised while a fill is outstanding
        fixed_delay = 3;
        issue(32'h40);
        flush_pulse();
        check("fd_fill_pending", 64'(bus.mem_req), 64'd1);
        drain();
        fixed_delay = -1;
        issue(32'h40);
        drain();
        check_counts("fd");

        // Reset in the middle of a miss
        resp_block = 1'b1;
        issue(32'h80);
        check("rm_mem_req", 64'(bus.mem_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rm_mem_req_low", 64'(bus.mem_req), 64'd0);
        check("rm_resp_valid", 64'(bus.resp_valid), 64'd0);
        late_cnt++;
        repeat (2) begin
            @(negedge clk);
            check("rm_late_ignored", 64'(bus.resp_valid), 64'd0);
        end
        resp_block = 1'b0;
        issue(32'h40);
        drain();
        check_counts("rm");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                flush_pulse();
            end else if (r < 7) begin
                wait_ready();
                salt = $urandom;
            end else if (r < 12) begin
                @(negedge clk);
            end else begin
                issue(AW'($urandom_range(0, 63) * 4));
            end
        end
        drain();
        check_counts("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
